// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add_ctrl
//  Description : Drives one external 4-bit ripple-carry adder slice to do a
//                wide add or subtract, one nibble per clock, LSB nibble first.
//                Operands come in on a valid/ready start handshake. Sum,
//                carry-out and signed overflow go out on a valid/ready result
//                handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 sub,
    input  logic                 cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout
);

    localparam int              W      = 4 * NIBBLES;
    localparam int              KW     = $clog2(NIBBLES);
    localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [KW-1:0]  r_k;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;          // already inverted for subtract
    logic           r_c;          // carry between nibbles
    logic [W-1:0]   r_result;
    logic           r_cout;
    logic           r_ovf;
    logic           r_start_ready;
    logic           r_res_valid;
    logic           r_busy;

    logic           w_run;
    logic [KW+1:0]  w_base;       // bit offset of the active nibble
    logic           w_last;
    logic           w_msb_cin;    // carry into the top bit, recovered from the slice sum

    assign w_run     = (r_state == S_RUN);
    assign w_base    = {r_k, 2'b00};
    assign w_last    = (r_k == K_LAST);
    assign w_msb_cin = r_a[W-1] ^ r_b[W-1] ^ add_s[3];

    // Slice inputs are only live in RUN; otherwise held at zero.
    assign add_a   = w_run ? r_a[w_base +: 4] : 4'd0;
    assign add_b   = w_run ? r_b[w_base +: 4] : 4'd0;
    assign add_cin = w_run & r_c;

    assign start_ready = r_start_ready;
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;
    assign result      = r_result;
    assign cout        = r_cout;
    assign ovf         = r_ovf;

    // Control FSM plus operand/result datapath with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= 1'b0;
            r_result      <= '0;
            r_cout        <= 1'b0;
            r_ovf         <= 1'b0;
            r_start_ready <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // start_ready comes up on the first clock after reset release
                    r_start_ready <= 1'b1;
                    if (r_start_ready && start_valid) begin
                        r_a           <= op_a;
                        r_b           <= sub ? ~op_b : op_b;
                        r_c           <= sub ? 1'b1 : cin;
                        r_k           <= '0;
                        r_state       <= S_RUN;
                        r_start_ready <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result[w_base +: 4] <= add_s;
                    r_c                   <= add_cout;
                    if (w_last) begin
                        r_cout      <= add_cout;
                        r_ovf       <= w_msb_cin ^ add_cout;
                        r_state     <= S_DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_start_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_start_ready <= 1'b0;
                    r_res_valid   <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_add_ctrl
//  Description : Self-checking bench for nibble_serial_add_ctrl with a
//                behavioural 4-bit adder slice and a whole-word reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          sub = 1'b0;
    logic          cin = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  result;
    logic          cout;
    logic          ovf;
    logic          busy;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_s;
    logic          add_cout;
    logic [4:0]    slice_sum;

    int errors = 0;
    int checks = 0;

    // expected outcome of the operation in flight
    logic [W-1:0]  exp_res = '0;
    logic          exp_c   = 1'b0;
    logic          exp_o   = 1'b0;

    always #5 clk = ~clk;

    // behavioural 4-bit adder slice
    assign slice_sum = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    assign add_s     = slice_sum[3:0];
    assign add_cout  = slice_sum[4];

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub        (sub),
        .cin        (cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .result     (result),
        .cout       (cout),
        .ovf        (ovf),
        .busy       (busy),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .add_cout   (add_cout)
    );

    // Whole-word reference: {ovf, cout, result}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s, input logic ci);
        logic [W-1:0] bx;
        logic [W:0]   t;
        logic         o;
        bx = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        o  = (a[W-1] == bx[W-1]) && (t[W-1] != a[W-1]);
        return {o, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (start_ready && res_valid)
                    check("ready_valid_exclusive", 32'(start_ready & res_valid), 32'd0);
                if (!busy)
                    check("slice_idle_zero", {23'd0, add_a, add_b, add_cin}, 32'd0);
                if (res_valid) begin
                    check("cycle_result", 32'(result), 32'(exp_res));
                    check("cycle_cout", 32'(cout), 32'(exp_c));
                    check("cycle_ovf", 32'(ovf), 32'(exp_o));
                end
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci, input int stall,
                         input bit pulse, input bit lit, input logic [W-1:0] lit_res,
                         input logic lit_c, input logic lit_o);
        int n;
        logic [W+1:0] m;
        n = 0;
        @(negedge clk);
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) check("start_ready_timeout", 32'(start_ready), 32'd1);
        m = model(a, b, s, ci);
        exp_res = m[W-1:0];
        exp_c   = m[W];
        exp_o   = m[W+1];
        op_a = a; op_b = b; sub = s; cin = ci;
        start_valid = 1'b1;
        @(negedge clk);
        // accepted; scramble operands so a re-sample would be visible
        op_a = ~a; op_b = ~b; sub = ~s;
        start_valid = pulse;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start_valid = 1'b0;
        end while (!res_valid && n < 20);
        check("latency", 32'(n), 32'(NIBBLES));
        if (lit) begin
            check("lit_result", 32'(result), 32'(lit_res));
            check("lit_cout", 32'(cout), 32'(lit_c));
            check("lit_ovf", 32'(ovf), 32'(lit_o));
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_hold", {30'd0, res_valid, start_ready}, 32'b10);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("result_released", 32'(res_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [W+1:0] mm;

        // model pinned against hand-computed values
        mm = model(16'h1234, 16'h0F0F, 1'b0, 1'b0);
        check("model_add", 32'(mm), {14'd0, 2'b00, 16'h2143});
        mm = model(16'h0005, 16'h0007, 1'b1, 1'b0);
        check("model_sub", 32'(mm), {14'd0, 2'b00, 16'hFFFE});

        // reset state
        #12;
        check("reset_outputs", {12'd0, start_ready, res_valid, busy, cout, ovf, add_cin, result},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 32'(start_ready), 32'd1);

        do_op(16'h1234, 16'h0F0F, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h2143, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 3, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0);

        // asynchronous reset in the middle of RUN at k=2
        @(negedge clk);
        op_a = 16'h1234; op_b = 16'h0F0F; sub = 1'b0; cin = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #2 start_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {3'd0, start_ready, res_valid, busy, cout, ovf, add_a, add_b, add_cin, result[10:0]},
              32'd0);
        check("async_reset_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_after_async_reset", {30'd0, start_ready, busy}, 32'b10);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);

        // random operations checked by the per-cycle model compare
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
